// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII receive path and its FCS logic.
package ether_pkg;

  typedef enum logic [2:0] {
    StArm,
    StIdle,
    StPreamble,
    StData,
    StDrop
  } rx_state_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;

endpackage

// File: rtl/crc32_dibit_step.sv
// Combinational reflected CRC-32 update for one RMII dibit, bit 0 first.
module crc32_dibit_step
  import ether_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/ether_rx_packer.sv
// RMII receiver: preamble/SFD lock, FCS check and optional strip, byte-to-word packing.
module ether_rx_packer
  import ether_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter bit          STRIP_FCS  = 1'b1,
  parameter int unsigned MAX_BYTES  = 1518
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             eth_crsdv,
  input  logic [1:0]                       eth_rxd,
  output logic [8*WORD_BYTES-1:0]          axiod,
  output logic [WORD_BYTES-1:0]            axiok,
  output logic                             axiov,
  output logic                             axiol,
  output logic                             frame_done,
  output logic                             frame_ok,
  output logic [$clog2(MAX_BYTES+1)-1:0]   frame_len
);

  localparam int unsigned LenW = $clog2(MAX_BYTES + 1);
  localparam int unsigned PkW  = $clog2(WORD_BYTES + 1);
  localparam int unsigned DW   = 8 * WORD_BYTES;

  rx_state_t             state_q, state_d;
  logic [31:0]           crc_q, crc_d, crc_next;
  logic [1:0]            phase_q, phase_d;
  logic [5:0]            shreg_q, shreg_d;
  logic [LenW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [LenW-1:0]       rel_cnt_q, rel_cnt_d;
  logic [3:0][7:0]       dl_q, dl_d;
  logic [2:0]            dl_cnt_q, dl_cnt_d;
  logic [DW-1:0]         word_q, word_d;
  logic [PkW-1:0]        pk_cnt_q, pk_cnt_d;

  logic [DW-1:0]         axiod_q, axiod_d;
  logic [WORD_BYTES-1:0] axiok_q, axiok_d;
  logic                  axiov_q, axiov_d;
  logic                  axiol_q, axiol_d;
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic [LenW-1:0]       len_q, len_d;

  logic [7:0]            new_byte;
  logic [7:0]            rel_byte;
  logic                  rel;
  logic                  flush;

  function automatic logic [DW-1:0] place(input logic [DW-1:0] w, input logic [PkW-1:0] idx,
                                          input logic [7:0] b);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (PkW'(i) == idx) r[DW-1-8*i -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [PkW-1:0] cnt);
    logic [WORD_BYTES-1:0] m;
    for (int i = 0; i < WORD_BYTES; i++) begin
      m[WORD_BYTES-1-i] = (PkW'(i) < cnt);
    end
    return m;
  endfunction

  crc32_dibit_step u_crc_step (
    .crc      (crc_q),
    .dibit    (eth_rxd),
    .crc_next (crc_next)
  );

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    phase_d    = phase_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    word_d     = word_q;
    pk_cnt_d   = pk_cnt_q;
    axiod_d    = axiod_q;
    axiok_d    = axiok_q;
    axiov_d    = 1'b0;
    axiol_d    = 1'b0;
    done_d     = 1'b0;
    ok_d       = ok_q;
    len_d      = len_q;
    new_byte   = {eth_rxd, shreg_q};
    rel_byte   = new_byte;
    rel        = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      StArm: begin
        if (!eth_crsdv) state_d = StIdle;
      end
      StIdle: begin
        if (eth_crsdv && eth_rxd == PREAMBLE_DIBIT) state_d = StPreamble;
      end
      StPreamble: begin
        if (!eth_crsdv) begin
          state_d = StIdle;
        end else if (eth_rxd == SFD_DIBIT) begin
          state_d    = StData;
          crc_d      = CRC32_INIT;
          phase_d    = 2'd0;
          byte_cnt_d = '0;
          rel_cnt_d  = '0;
          dl_cnt_d   = 3'd0;
          pk_cnt_d   = '0;
          word_d     = '0;
        end else if (eth_rxd != PREAMBLE_DIBIT) begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!eth_crsdv) begin
          // A partial trailing byte is simply never completed.
          flush   = 1'b1;
          state_d = StIdle;
          done_d  = 1'b1;
          ok_d    = (crc_q == CRC32_RESIDUE) && (phase_q == 2'd0) &&
                    (!STRIP_FCS || byte_cnt_q >= LenW'(4));
          len_d   = rel_cnt_q;
        end else begin
          crc_d   = crc_next;
          phase_d = phase_q + 2'd1;
          shreg_d = new_byte[7:2];
          if (phase_q == 2'd3) begin
            if (byte_cnt_q == LenW'(MAX_BYTES)) begin
              flush   = 1'b1;
              done_d  = 1'b1;
              ok_d    = 1'b0;
              len_d   = rel_cnt_q;
              state_d = StDrop;
            end else begin
              byte_cnt_d = byte_cnt_q + LenW'(1);
              if (STRIP_FCS) begin
                // dl_q[3] is the oldest byte; it leaves only once four newer ones exist.
                dl_d = {dl_q[2:0], new_byte};
                if (dl_cnt_q == 3'd4) begin
                  rel      = 1'b1;
                  rel_byte = dl_q[3];
                end else begin
                  dl_cnt_d = dl_cnt_q + 3'd1;
                end
              end else begin
                rel = 1'b1;
              end
            end
          end
        end
      end
      StDrop: begin
        if (!eth_crsdv) state_d = StIdle;
      end
      default: state_d = StArm;
    endcase

    if (rel) begin
      rel_cnt_d = rel_cnt_q + LenW'(1);
      if (pk_cnt_q == PkW'(WORD_BYTES)) begin
        axiov_d  = 1'b1;
        axiod_d  = word_q;
        axiok_d  = '1;
        word_d   = place('0, '0, rel_byte);
        pk_cnt_d = PkW'(1);
      end else begin
        word_d   = place(word_q, pk_cnt_q, rel_byte);
        pk_cnt_d = pk_cnt_q + PkW'(1);
      end
    end

    if (flush && pk_cnt_q != '0) begin
      axiov_d = 1'b1;
      axiol_d = 1'b1;
      axiod_d = word_q;
      axiok_d = keep_mask(pk_cnt_q);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StArm;
      crc_q      <= CRC32_INIT;
      phase_q    <= 2'd0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      rel_cnt_q  <= '0;
      dl_q       <= '0;
      dl_cnt_q   <= 3'd0;
      word_q     <= '0;
      pk_cnt_q   <= '0;
      axiod_q    <= '0;
      axiok_q    <= '0;
      axiov_q    <= 1'b0;
      axiol_q    <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      word_q     <= word_d;
      pk_cnt_q   <= pk_cnt_d;
      axiod_q    <= axiod_d;
      axiok_q    <= axiok_d;
      axiov_q    <= axiov_d;
      axiol_q    <= axiol_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      len_q      <= len_d;
    end
  end

  assign axiod      = axiod_q;
  assign axiok      = axiok_q;
  assign axiov      = axiov_q;
  assign axiol      = axiol_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign frame_len  = len_q;

endmodule

// File: tb/tb_ether_rx_packer.sv
// Drives four packer configurations with the same RMII stream and checks frames from a table.
module tb_ether_rx_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;

  always #10 clk = ~clk;

  logic [31:0] d4;  logic [3:0] k4;  logic v4, l4, dn4, ok4;  logic [10:0] len4;
  logic [7:0]  d1;  logic [0:0] k1;  logic v1, l1, dn1, ok1;  logic [10:0] len1;
  logic [63:0] d8;  logic [7:0] k8;  logic v8, l8, dn8, ok8;  logic [10:0] len8;
  logic [31:0] dn_d; logic [3:0] kn; logic vn, ln, dnn, okn; logic [10:0] lenn;

  ether_rx_packer #(.WORD_BYTES(4), .STRIP_FCS(1'b1), .MAX_BYTES(1518)) u4 (
    .clk_in(clk), .rst_in(rst), .eth_crsdv(crsdv), .eth_rxd(rxd), .axiod(d4), .axiok(k4),
    .axiov(v4), .axiol(l4), .frame_done(dn4), .frame_ok(ok4), .frame_len(len4));
  ether_rx_packer #(.WORD_BYTES(1), .STRIP_FCS(1'b1), .MAX_BYTES(1518)) u1 (
    .clk_in(clk), .rst_in(rst), .eth_crsdv(crsdv), .eth_rxd(rxd), .axiod(d1), .axiok(k1),
    .axiov(v1), .axiol(l1), .frame_done(dn1), .frame_ok(ok1), .frame_len(len1));
  ether_rx_packer #(.WORD_BYTES(8), .STRIP_FCS(1'b1), .MAX_BYTES(1518)) u8 (
    .clk_in(clk), .rst_in(rst), .eth_crsdv(crsdv), .eth_rxd(rxd), .axiod(d8), .axiok(k8),
    .axiov(v8), .axiol(l8), .frame_done(dn8), .frame_ok(ok8), .frame_len(len8));
  ether_rx_packer #(.WORD_BYTES(4), .STRIP_FCS(1'b0), .MAX_BYTES(1518)) un (
    .clk_in(clk), .rst_in(rst), .eth_crsdv(crsdv), .eth_rxd(rxd), .axiod(dn_d), .axiok(kn),
    .axiov(vn), .axiol(ln), .frame_done(dnn), .frame_ok(okn), .frame_len(lenn));

  int checks = 0;
  int failures = 0;
  int wb [4] = '{4, 1, 8, 4};

  logic [7:0] rxb [4][2048];
  int rxn [4], beats [4], lasts [4], dones [4], bad [4], lenc [4];
  logic okc [4];
  logic [31:0] b4d [8];
  logic [3:0]  b4k [8];
  logic        b4l [8];

  logic [7:0] sent [2048];
  int sent_n;

  typedef struct {
    int n;        // payload bytes before FCS
    bit flip;     // corrupt one FCS bit
    int extra;    // trailing stray dibits
    bit ok;
    int len_s;    // frame_len with FCS stripped
    int len_n;    // frame_len with FCS passed
  } frame_vec_t;

  frame_vec_t vec [8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic l, input logic [63:0] d,
                     input int w, input logic [7:0] kp, input logic dn, input logic ok,
                     input int len);
    int n;
    bit gap;
    logic [63:0] tmp;
    if (v) begin
      beats[k]++;
      n = 0;
      gap = 1'b0;
      for (int i = 0; i < w; i++) begin
        if (kp[w-1-i]) begin
          if (gap) bad[k]++;
          tmp = d >> (8 * (w - 1 - i));
          if (rxn[k] < 2048) rxb[k][rxn[k]] = tmp[7:0];
          rxn[k]++;
          n++;
        end else begin
          gap = 1'b1;
        end
      end
      if (n == 0 || (!l && n != w)) bad[k]++;
      if (l) begin
        lasts[k]++;
        if (!dn) bad[k]++;
      end
      if (k == 0 && beats[0] <= 8) begin
        b4d[beats[0]-1] = d[31:0];
        b4k[beats[0]-1] = kp[3:0];
        b4l[beats[0]-1] = l;
      end
    end
    if (dn) begin
      dones[k]++;
      okc[k] = ok;
      lenc[k] = len;
    end
  endtask

  always @(negedge clk) mon(0, v4, l4, 64'(d4), 4, 8'(k4), dn4, ok4, int'(len4));
  always @(negedge clk) mon(1, v1, l1, 64'(d1), 1, 8'(k1), dn1, ok1, int'(len1));
  always @(negedge clk) mon(2, v8, l8, d8, 8, k8, dn8, ok8, int'(len8));
  always @(negedge clk) mon(3, vn, ln, 64'(dn_d), 4, 8'(kn), dnn, okn, int'(lenn));

  task automatic clear_caps();
    for (int k = 0; k < 4; k++) begin
      rxn[k] = 0; beats[k] = 0; lasts[k] = 0; dones[k] = 0; bad[k] = 0;
      lenc[k] = -1; okc[k] = 1'bx;
    end
  endtask

  task automatic dibit(input logic cv, input logic [1:0] d);
    @(posedge clk);
    #1;
    crsdv = cv;
    rxd = d;
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic send_frame(input int n, input bit flip, input int extra);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0] b;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      sent[i] = b;
      crc = crc_byte(crc, b);
    end
    fcs = ~crc;
    for (int j = 0; j < 4; j++) sent[n+j] = fcs[8*j +: 8];
    if (flip) sent[n] = sent[n] ^ 8'h01;
    sent_n = n + 4;
    for (int i = 0; i < 15; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b11);
    for (int i = 0; i < sent_n; i++) begin
      b = sent[i];
      for (int j = 0; j < 4; j++) dibit(1'b1, b[2*j +: 2]);
    end
    for (int i = 0; i < extra; i++) dibit(1'b1, 2'b01);
    for (int i = 0; i < 4; i++) dibit(1'b0, 2'b00);
  endtask

  task automatic check_frame(input string tag, input bit ok, input int len_s, input int len_n);
    int len;
    int mism;
    string nm;
    for (int k = 0; k < 4; k++) begin
      len = (k == 3) ? len_n : len_s;
      nm = $sformatf("%s dut%0d", tag, k);
      check({nm, " dones"}, dones[k], 1);
      check({nm, " frame_ok"}, longint'(okc[k]), longint'(ok));
      check({nm, " frame_len"}, lenc[k], len);
      check({nm, " nbytes"}, rxn[k], len);
      mism = 0;
      for (int i = 0; i < len && i < 2048; i++) if (rxb[k][i] !== sent[i]) mism++;
      check({nm, " byte_mismatches"}, mism, 0);
      check({nm, " beats"}, beats[k], (len + wb[k] - 1) / wb[k]);
      check({nm, " last_beats"}, lasts[k], (len > 0) ? 1 : 0);
      check({nm, " beat_format_errors"}, bad[k], 0);
    end
    check({tag, " frame_len_held"}, int'(len4), len_s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{n: 10,   flip: 1'b0, extra: 0, ok: 1'b1, len_s: 10,   len_n: 14};
    vec[1] = '{n: 10,   flip: 1'b1, extra: 0, ok: 1'b0, len_s: 10,   len_n: 14};
    vec[2] = '{n: 8,    flip: 1'b0, extra: 0, ok: 1'b1, len_s: 8,    len_n: 12};
    vec[3] = '{n: 6,    flip: 1'b0, extra: 1, ok: 1'b0, len_s: 6,    len_n: 10};
    vec[4] = '{n: 1515, flip: 1'b0, extra: 0, ok: 1'b0, len_s: 1514, len_n: 1518};
    vec[5] = '{n: 10,   flip: 1'b0, extra: 0, ok: 1'b1, len_s: 10,   len_n: 14};
    vec[6] = '{n: 0,    flip: 1'b0, extra: 0, ok: 1'b1, len_s: 0,    len_n: 4};
    vec[7] = '{n: 1514, flip: 1'b0, extra: 0, ok: 1'b1, len_s: 1514, len_n: 1518};

    clear_caps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset axiod", d4, 0);
    check("reset axiok", k4, 0);
    check("reset axiov", v4, 0);
    check("reset axiol", l4, 0);
    check("reset frame_done", dn4, 0);
    check("reset frame_ok", ok4, 0);
    check("reset frame_len", len4, 0);
    check("reset others", {d8, dn_d, d1, k8, kn, k1, v1, v8, vn, dn1, dn8, dnn, len1, len8, lenn},
          0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 8; t++) begin
      clear_caps();
      send_frame(vec[t].n, vec[t].flip, vec[t].extra);
      check_frame($sformatf("vec%0d", t), vec[t].ok, vec[t].len_s, vec[t].len_n);
      if (t <= 1) begin
        check($sformatf("vec%0d beat0", t), {b4d[0], b4k[0], b4l[0]}, {32'h00010203, 4'hF, 1'b0});
        check($sformatf("vec%0d beat1", t), {b4d[1], b4k[1], b4l[1]}, {32'h04050607, 4'hF, 1'b0});
        check($sformatf("vec%0d beat2", t), {b4d[2] & 32'hFFFF0000, b4k[2], b4l[2]},
              {32'h08090000, 4'hC, 1'b1});
      end
      if (t == 2) begin
        check("vec2 beat1", {b4d[1], b4k[1], b4l[1]}, {32'h04050607, 4'hF, 1'b1});
      end
    end

    // Reset mid-payload with carrier held: block must wait in ARM until carrier drops.
    for (int i = 0; i < 15; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b11);
    for (int i = 0; i < 20; i++) dibit(1'b1, 2'(i));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) dibit(1'b1, 2'b10);
    #1 rst = 1'b0;
    clear_caps();
    @(negedge clk);
    check("midreset axiov", {vn, v4, v1, v8}, 0);
    check("midreset frame_len", {lenn, len4}, 0);
    for (int i = 0; i < 10; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b11);
    for (int i = 0; i < 19; i++) dibit(1'b1, 2'b10);
    for (int i = 0; i < 4; i++) dibit(1'b0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midreset dut%0d dones", k), dones[k], 0);
      check($sformatf("midreset dut%0d beats", k), beats[k], 0);
    end
    clear_caps();
    send_frame(10, 1'b0, 0);
    check_frame("after_reset", 1'b1, 10, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
